// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-way traffic-light sequencer.
// Holds the phase encoding, the lamp bundle driven in each phase, and the
// helpers that map a phase to its successor, its lamps and its duration.
package semaforo_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLEAR1   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLEAR2   = 3'd5
  } phase_t;

  // Bit order matches the display top's lamp inputs: VA AA RA VB AB RB.
  typedef struct packed {
    logic va;
    logic aa;
    logic ra;
    logic vb;
    logic ab;
    logic rb;
  } lamps_t;

  localparam lamps_t LAMPS_A_GREEN  = 6'b100001;
  localparam lamps_t LAMPS_A_YELLOW = 6'b010001;
  localparam lamps_t LAMPS_CLEAR    = 6'b001001;
  localparam lamps_t LAMPS_B_GREEN  = 6'b001100;
  localparam lamps_t LAMPS_B_YELLOW = 6'b001010;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      A_GREEN:  next_phase = A_YELLOW;
      A_YELLOW: next_phase = CLEAR1;
      CLEAR1:   next_phase = B_GREEN;
      B_GREEN:  next_phase = B_YELLOW;
      B_YELLOW: next_phase = CLEAR2;
      default:  next_phase = A_GREEN;
    endcase
  endfunction

  // Unused encodings fall back to all-red clearance, the safe state.
  function automatic lamps_t phase_lamps(input phase_t p);
    case (p)
      A_GREEN:  phase_lamps = LAMPS_A_GREEN;
      A_YELLOW: phase_lamps = LAMPS_A_YELLOW;
      B_GREEN:  phase_lamps = LAMPS_B_GREEN;
      B_YELLOW: phase_lamps = LAMPS_B_YELLOW;
      default:  phase_lamps = LAMPS_CLEAR;
    endcase
  endfunction

  function automatic logic [3:0] phase_dur(input phase_t p, input int t_green,
                                           input int t_yellow, input int t_allred);
    case (p)
      A_GREEN, B_GREEN:   phase_dur = 4'(t_green);
      A_YELLOW, B_YELLOW: phase_dur = 4'(t_yellow);
      default:            phase_dur = 4'(t_allred);
    endcase
  endfunction

endpackage

// File: rtl/semaforo_controller_tick_gen.sv
// tick_gen: divides clk down to a one-cycle pulse every TICKS_PER_SEC cycles.
// Ports: clk, rst (sync, active high), en (0 freezes the counter and
// suppresses the pulse), tick (high in the cycle the counter is at its last
// value while en=1).
module tick_gen #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == LAST) pcnt <= '0;
      else              pcnt <= pcnt + CW'(1);
    end
  end

endmodule

// File: rtl/semaforo_controller.sv
// semaforo_controller: six-phase two-way intersection sequencer.
// Ports: clk, rst (sync, active high, beats en), en (0 freezes everything),
// req_b (street-B vehicle request, level), VA/AA/RA and VB/AB/RB lamps
// (registered), Numero (seconds left in the phase, 1..9, registered),
// tick (1 s debug pulse from the prescaler).
module semaforo_controller
  import semaforo_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int T_GREEN       = 9,
  parameter int T_YELLOW      = 3,
  parameter int T_ALLRED      = 1,
  parameter int T_MIN_LEFT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_b,
  output logic       VA,
  output logic       AA,
  output logic       RA,
  output logic       VB,
  output logic       AB,
  output logic       RB,
  output logic [3:0] Numero,
  output logic       tick
);

  localparam bit PARAMS_OK =
    (T_GREEN    >= 1) && (T_GREEN    <= 9) &&
    (T_YELLOW   >= 1) && (T_YELLOW   <= 9) &&
    (T_ALLRED   >= 1) && (T_ALLRED   <= 9) &&
    (T_MIN_LEFT >= 1) && (T_MIN_LEFT <= 9) &&
    (T_MIN_LEFT < T_GREEN) && (TICKS_PER_SEC >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $fatal(1, "semaforo_controller: phase durations must be 1..9 and T_MIN_LEFT < T_GREEN");
  end

  // Truncation only pays off when more than T_MIN_LEFT+1 seconds remain.
  localparam logic [3:0] MIN_LEFT  = 4'(T_MIN_LEFT);
  localparam logic [3:0] TRUNC_THR = 4'(T_MIN_LEFT + 1);

  phase_t     phase;
  lamps_t     lamps;
  logic [3:0] numero;
  logic       req_q;

  tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= A_GREEN;
      numero <= 4'(T_GREEN);
      lamps  <= LAMPS_A_GREEN;
      req_q  <= 1'b0;
    end else if (en) begin
      // A request arriving on a tick edge is latched now but only the next
      // tick sees it, because the truncation test below reads the old req_q.
      if (req_b) req_q <= 1'b1;
      if (tick) begin
        if (numero == 4'd1) begin
          phase  <= next_phase(phase);
          numero <= phase_dur(next_phase(phase), T_GREEN, T_YELLOW, T_ALLRED);
          lamps  <= phase_lamps(next_phase(phase));
          // Serving B consumes the request; this overrides a same-edge set.
          if (next_phase(phase) == B_GREEN) req_q <= 1'b0;
        end else if (phase == A_GREEN && req_q && numero > TRUNC_THR) begin
          numero <= MIN_LEFT;
        end else begin
          numero <= numero - 4'd1;
        end
      end
    end
  end

  assign VA     = lamps.va;
  assign AA     = lamps.aa;
  assign RA     = lamps.ra;
  assign VB     = lamps.vb;
  assign AB     = lamps.ab;
  assign RB     = lamps.rb;
  assign Numero = numero;

endmodule

// File: tb/tb_semaforo_controller.sv
module tb_semaforo_controller;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req_b;
  logic       VA, AA, RA, VB, AB, RB;
  logic [3:0] Numero;
  logic       tick;
  logic [5:0] lamps_obs;

  int vectors = 0;
  int miscompares = 0;

  // Expected lamps ({VA,AA,RA,VB,AB,RB}) and durations per phase, in order.
  localparam logic [5:0] LAMP_TAB [6] = '{6'b100001, 6'b010001, 6'b001001,
                                         6'b001100, 6'b001010, 6'b001001};
  localparam int DUR_TAB [6] = '{9, 3, 1, 9, 3, 1};

  localparam logic [5:0] L_AG = 6'b100001;
  localparam logic [5:0] L_AY = 6'b010001;
  localparam logic [5:0] L_CL = 6'b001001;
  localparam logic [5:0] L_BG = 6'b001100;
  localparam logic [5:0] L_BY = 6'b001010;

  semaforo_controller #(
    .TICKS_PER_SEC(4),
    .T_GREEN(9),
    .T_YELLOW(3),
    .T_ALLRED(1),
    .T_MIN_LEFT(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req_b  (req_b),
    .VA     (VA),
    .AA     (AA),
    .RA     (RA),
    .VB     (VB),
    .AB     (AB),
    .RB     (RB),
    .Numero (Numero),
    .tick   (tick)
  );

  assign lamps_obs = {VA, AA, RA, VB, AB, RB};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req;
    req_b = 1'b1;
    step(1);
    req_b = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_phase(input string tag, input logic [5:0] exp_lamps, input int exp_num);
    chk({tag, "_lamps"}, 32'(lamps_obs), 32'(exp_lamps));
    chk({tag, "_numero"}, 32'(Numero), 32'(exp_num));
  endtask

  task automatic chk_invariants(input string tag);
    chk({tag, "_onehot_a"}, 32'($onehot({VA, AA, RA})), 32'd1);
    chk({tag, "_onehot_b"}, 32'($onehot({VB, AB, RB})), 32'd1);
    chk({tag, "_no_dual_green"}, 32'(VA & VB), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    req_b = 1'b0;

    // Reset held for three edges, then first cycle after release
    step(3);
    rst = 1'b0;
    chk_phase("reset", L_AG, 9);
    chk("reset_tick", 32'(tick), 32'd0);
    chk_invariants("reset");

    // Full cycle: 104 cycles, 4 per second, no requests
    for (int p = 0; p < 6; p++) begin
      for (int s = DUR_TAB[p]; s >= 1; s--) begin
        for (int k = 0; k < 4; k++) begin
          chk_phase($sformatf("cycle_p%0d_s%0d_k%0d", p, s, k), LAMP_TAB[p], s);
          chk($sformatf("cycle_tick_p%0d_s%0d_k%0d", p, s, k), 32'(tick), 32'(k == 3));
          chk_invariants($sformatf("cycle_p%0d_s%0d_k%0d", p, s, k));
          step(1);
        end
      end
    end
    chk_phase("cycle_wrap", L_AG, 9);

    // Request at Numero=7 truncates to T_MIN_LEFT on the next tick
    step(8);
    chk_phase("trunc_pre", L_AG, 7);
    pulse_req();
    chk("trunc_req_latched", 32'(dut.req_q), 32'd1);
    step(3);
    chk_phase("trunc_loaded", L_AG, 2);
    step(7);
    chk_phase("trunc_last_green", L_AG, 1);
    step(1);
    chk_phase("trunc_yellow", L_AY, 3);

    // Through CLEAR1 into B_GREEN; request cleared on entry
    step(16);
    chk_phase("bgreen_entry", L_BG, 9);
    chk("bgreen_req_cleared", 32'(dut.req_q), 32'd0);
    step(36);
    chk_phase("byellow_entry", L_BY, 3);

    // Pause in B_YELLOW with Numero=2 on the cycle that would tick
    step(7);
    chk_phase("pause_pre", L_BY, 2);
    chk("pause_pre_tick", 32'(tick), 32'd1);
    en = 1'b0;
    #1;
    chk("pause_tick_off", 32'(tick), 32'd0);
    step(25);
    chk("pause_mid_tick", 32'(tick), 32'd0);
    chk_phase("pause_mid", L_BY, 2);
    step(25);
    chk("pause_end_tick", 32'(tick), 32'd0);
    chk_phase("pause_end", L_BY, 2);
    chk("pause_pcnt", 32'(dut.u_tick.pcnt), 32'd3);
    en = 1'b1;
    #1;
    chk("resume_tick", 32'(tick), 32'd1);
    step(1);
    chk_phase("resume_dec", L_BY, 1);
    step(3);
    chk_phase("resume_last", L_BY, 1);
    step(1);
    chk_phase("clear2", L_CL, 1);
    step(4);
    chk_phase("agreen_again", L_AG, 9);

    // Request at Numero=3: no truncation, normal countdown
    step(24);
    chk_phase("notrunc_pre", L_AG, 3);
    pulse_req();
    chk("notrunc_req_latched", 32'(dut.req_q), 32'd1);
    step(3);
    chk_phase("notrunc_dec", L_AG, 2);
    step(4);
    chk_phase("notrunc_one", L_AG, 1);
    step(4);
    chk_phase("notrunc_yellow", L_AY, 3);

    // Mid-operation reset in B_GREEN with a pending request, en low too
    step(16);
    chk_phase("rst_bgreen", L_BG, 9);
    pulse_req();
    chk("rst_req_set", 32'(dut.req_q), 32'd1);
    step(5);
    rst = 1'b1;
    en  = 1'b0;
    step(1);
    rst = 1'b0;
    en  = 1'b1;
    chk_phase("rst_mid", L_AG, 9);
    chk("rst_mid_tick", 32'(tick), 32'd0);
    chk("rst_mid_req", 32'(dut.req_q), 32'd0);
    chk("rst_mid_pcnt", 32'(dut.u_tick.pcnt), 32'd0);
    chk_invariants("rst_mid");

    // The following A_GREEN runs its full 36 cycles
    step(8);
    chk_phase("post_rst_7", L_AG, 7);
    step(27);
    chk_phase("post_rst_last", L_AG, 1);
    step(1);
    chk_phase("post_rst_yellow", L_AY, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/semaforo_controller.md
Name: semaforo_controller

Overview:
- Two-way intersection traffic-light sequencer; directly upstream of the VGA display top.
- Drives that top's six lamp inputs (VA, AA, RA, VB, AB, RB) and its 4-bit countdown digit (Numero).
- Divides the 100 MHz system clock to a 1 s tick and steps a six-phase FSM.
- A latched side-street request on B can shorten A's green phase.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per second tick; benches use a small value.
- T_GREEN, 9, green duration in seconds; range 1..9.
- T_YELLOW, 3, yellow duration in seconds; range 1..9.
- T_ALLRED, 1, all-red clearance in seconds; range 1..9.
- T_MIN_LEFT, 2, seconds of A green kept after a honoured B request; must be less than T_GREEN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  in  1  1 = run; 0 = freeze the prescaler, FSM, countdown and request latch (lamps hold).
- req_b  in  1  vehicle request on street B; level, sampled every cycle.
- VA  out  1  green, street A.
- AA  out  1  yellow, street A.
- RA  out  1  red, street A.
- VB  out  1  green, street B.
- AB  out  1  yellow, street B.
- RB  out  1  red, street B.
- Numero  out  4  seconds remaining in the current phase; always 1..9.
- tick  out  1  one-cycle pulse at each second boundary, for debug.

Behaviour:
- Prescaler:
  - Counter pcnt counts 0..TICKS_PER_SEC-1 while en=1.
  - tick=1 in the cycle pcnt==TICKS_PER_SEC-1 and en=1; pcnt then wraps to 0.
  - When en=0, pcnt holds and tick=0.
- FSM phases, in order A_GREEN, A_YELLOW, CLEAR1, B_GREEN, B_YELLOW, CLEAR2, then back to A_GREEN.
- Phase durations:
  - A_GREEN and B_GREEN: T_GREEN.
  - A_YELLOW and B_YELLOW: T_YELLOW.
  - CLEAR1 and CLEAR2: T_ALLRED.
- Countdown:
  - On a tick with Numero>1, Numero decrements.
  - On a tick with Numero==1, the FSM advances and Numero loads the next phase's duration, in the same edge.
  - Each phase therefore lasts exactly duration×TICKS_PER_SEC cycles.
- Lamps (registered, updated on the same edge as state):
  - A_GREEN: VA=1, RB=1.
  - A_YELLOW: AA=1, RB=1.
  - CLEAR1 and CLEAR2: RA=1, RB=1.
  - B_GREEN: VB=1, RA=1.
  - B_YELLOW: AB=1, RA=1.
  - All other lamps are 0.
- Lamp invariants:
  - Exactly one of {VA, AA, RA} is 1, and exactly one of {VB, AB, RB} is 1, every cycle including reset.
  - VA and VB are never both 1.
- Request latch req_q:
  - Set when req_b=1 and en=1.
  - Cleared on entry to B_GREEN.
- Green truncation:
  - Applies on a tick in A_GREEN with req_q=1 and Numero>T_MIN_LEFT+1.
  - Numero loads T_MIN_LEFT instead of decrementing.
  - Otherwise the normal countdown applies.
  - Truncation happens at most once per A_GREEN, because Numero is then ≤T_MIN_LEFT.
- Simultaneous req_b and tick: the request is latched that edge but affects only the next tick.
- Reset (at any point, including mid-phase):
  - State=A_GREEN, Numero=T_GREEN, pcnt=0, req_q=0, tick=0.
  - VA=1, RB=1, all other lamps 0.
  - Reset takes priority over en.
- Latency:
  - Lamp and Numero changes appear at the clk edge where tick=1 is sampled.
  - No combinational path from inputs to outputs.
- Width rules: Numero is 4 bits; durations are checked at elaboration, and any parameter outside 1..9 is a fatal error.

Decomposition:
- Shared package semaforo_pkg holds:
  - the phase enum (3-bit encoding);
  - a lamp bundle constant per phase;
  - the phase duration lookup function.
- Natural sub-module: tick_gen (TICKS_PER_SEC; inputs clk, rst, en; output tick), reusable by other timers in the design.

Test Plan:
- Reset check (TICKS_PER_SEC=4): assert rst for 3 cycles → VA=1, RB=1, other lamps 0, Numero=9, tick=0 on the first cycle after release.
- Full cycle (TICKS_PER_SEC=4, defaults, req_b=0):
  - A_GREEN lasts 36 cycles with Numero 9..1.
  - Then A_YELLOW lasts 12 cycles (3..1), CLEAR1 4 cycles, B_GREEN 36, B_YELLOW 12, CLEAR2 4.
  - Back in A_GREEN at cycle 104; the lamp one-hot invariants hold on every cycle.
- Request truncation:
  - Pulse req_b for 1 cycle while A_GREEN and Numero=7 → the next tick sets Numero=2.
  - A_YELLOW then starts 2 ticks later.
  - A req_b pulse when Numero=3 → no truncation; normal countdown continues.
- Pause: drop en for 50 cycles mid B_YELLOW with Numero=2 → tick stays 0; Numero, lamps and pcnt are frozen; the phase resumes with identical remaining cycles after en returns.
- Mid-operation reset: assert rst during B_GREEN with req_q set → the next cycle is A_GREEN, Numero=9, req_q=0; the following A_GREEN is not truncated.
- Elaboration check: T_GREEN=10 → simulation aborts with a fatal error.
